weight_mac_sequencer: RTL and testbench

Controller that owns one 28×16 weight BRAM and sequences it for a single neuron. In idle it accepts a streamed weight load from the host and converts it into BRAM write strobes. On START it walks the BRAM and a matching input-vector buffer in lockstep, and accumulates the signed dot product Σ W[i]·X[i]. It sits between the layer controller and a per-neuron weight BRAM, and is instantiated once per neuron.

---
 rtl/weight_mac_sequencer.sv | 148 ++++++++++++++
 tb/tb_weight_mac_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_mac_sequencer.sv
// weight_mac_sequencer
//   Owns one per-neuron weight BRAM. While idle it turns a streamed host weight
//   load into BRAM write strobes. On start it walks the weight BRAM and the
//   matching input-vector buffer in lockstep and accumulates the signed dot
//   product sum(W[i] * X[i]).
//
// Ports
//   clk, rst_n         system clock, asynchronous active-low reset
//   start              request a dot-product pass (sampled only in IDLE)
//   busy, done         pass in progress / one-cycle completion pulse
//   acc_out            signed result, held until the next accepted start
//   ld_valid/ld_ready  host weight-word handshake, ld_data is the word
//   ld_rst             synchronous clear of the load pointer (IDLE only)
//   bram_*             weight BRAM port (bram_do returns on the falling edge)
//   x_addr, x_data     input-vector buffer port, same timing as the BRAM
module weight_mac_sequencer #(
  parameter int DEPTH = 28,
  parameter int AW    = 5,
  parameter int DW    = 16,
  parameter int ACCW  = 40
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [ACCW-1:0] acc_out,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [DW-1:0]   ld_data,
  input  logic            ld_rst,
  output logic [AW-1:0]   bram_addr,
  output logic [DW-1:0]   bram_di,
  output logic            bram_en,
  output logic            bram_we,
  input  logic [DW-1:0]   bram_do,
  output logic [AW-1:0]   x_addr,
  input  logic [DW-1:0]   x_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                   state_reg;
  logic [AW-1:0]            idx_reg;
  logic [AW-1:0]            ld_ptr_reg;
  logic signed [2*DW-1:0]   prod_reg;
  logic                     prod_valid_reg;
  logic signed [ACCW-1:0]   acc_reg;
  logic [ACCW-1:0]          acc_out_reg;
  logic                     busy_reg;
  logic                     done_reg;

  logic                     is_idle;
  logic                     is_fetch;
  logic                     ld_wr;
  logic signed [ACCW-1:0]   prod_ext;
  logic signed [ACCW-1:0]   acc_sum;

  assign is_idle  = (state_reg == S_IDLE);
  assign is_fetch = (state_reg == S_FETCH);

  // start has priority over a simultaneous load word: ready drops with start.
  assign ld_ready = is_idle && !start;
  // Writes are suppressed while reset is held so the BRAM sees no strobe.
  assign ld_wr    = rst_n && ld_ready && ld_valid;

  assign bram_en   = ld_wr || is_fetch;
  assign bram_we   = ld_wr;
  assign bram_addr = is_fetch ? idx_reg : ld_ptr_reg;
  assign bram_di   = ld_wr ? ld_data : '0;
  assign x_addr    = is_fetch ? idx_reg : '0;

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign acc_out = acc_out_reg;

  assign prod_ext = {{(ACCW-2*DW){prod_reg[2*DW-1]}}, prod_reg};
  assign acc_sum  = acc_reg + prod_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      idx_reg        <= '0;
      ld_ptr_reg     <= '0;
      prod_reg       <= '0;
      prod_valid_reg <= 1'b0;
      acc_reg        <= '0;
      acc_out_reg    <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      // Two-stage MAC pipeline. bram_do/x_data settle on the falling edge, so
      // the product register closes a half-cycle path from the memories.
      prod_valid_reg <= is_fetch;
      if (is_fetch) begin
        prod_reg <= $signed(bram_do) * $signed(x_data);
      end
      if (prod_valid_reg) begin
        acc_reg <= acc_sum;
      end

      case (state_reg)
        S_IDLE: begin
          done_reg <= 1'b0;
          if (ld_rst) begin
            ld_ptr_reg <= '0;
          end else if (ld_wr) begin
            ld_ptr_reg <= (ld_ptr_reg == AW'(DEPTH-1)) ? '0 : ld_ptr_reg + AW'(1);
          end
          if (start) begin
            state_reg   <= S_FETCH;
            busy_reg    <= 1'b1;
            idx_reg     <= '0;
            acc_reg     <= '0;
            acc_out_reg <= '0;
          end
        end
        S_FETCH: begin
          if (idx_reg == AW'(DEPTH-1)) begin
            state_reg <= S_DRAIN;
          end else begin
            idx_reg <= idx_reg + AW'(1);
          end
        end
        S_DRAIN: begin
          // Last product is still in flight; fold it straight into the result.
          state_reg   <= S_DONE;
          done_reg    <= 1'b1;
          acc_out_reg <= acc_sum;
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_mac_sequencer.sv
module tb_weight_mac_sequencer;
  localparam int DEPTH = 28;
  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int ACCW  = 40;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            busy;
  logic            done;
  logic [ACCW-1:0] acc_out;
  logic            ld_valid;
  logic            ld_ready;
  logic [DW-1:0]   ld_data;
  logic            ld_rst;
  logic [AW-1:0]   bram_addr;
  logic [DW-1:0]   bram_di;
  logic            bram_en;
  logic            bram_we;
  logic [DW-1:0]   bram_do = '0;
  logic [AW-1:0]   x_addr;
  logic [DW-1:0]   x_data = '0;

  always #5 clk = ~clk;

  weight_mac_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .ACCW(ACCW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .acc_out(acc_out), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_rst(ld_rst), .bram_addr(bram_addr),
    .bram_di(bram_di), .bram_en(bram_en), .bram_we(bram_we),
    .bram_do(bram_do), .x_addr(x_addr), .x_data(x_data)
  );

  // Memories: falling-edge write commit and falling-edge registered read.
  logic [DW-1:0] mem  [0:31];
  logic [DW-1:0] xmem [0:31];
  always @(negedge clk) begin
    if (bram_en && bram_we) mem[bram_addr] <= bram_di;
    if (bram_en) bram_do <= mem[bram_addr];
    x_data <= xmem[x_addr];
  end

  int test_cnt = 0;
  int fail_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    test_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: cycles since start acceptance, weight image, pointer.
  int              m_cnt = 0;
  int              m_ptr = 0;
  logic [DW-1:0]   m_w [0:DEPTH-1];
  logic [ACCW-1:0] m_result = '0;
  logic [ACCW-1:0] m_acc_out = '0;
  bit              m_wr;
  bit              m_fetch;
  int              wr_count = 0;
  int              first_wr_addr = -1;
  int              last_wr_addr = -1;

  function automatic logic [ACCW-1:0] dot_product();
    longint s;
    s = 0;
    for (int i = 0; i < DEPTH; i++)
      s += longint'($signed(m_w[i])) * longint'($signed(xmem[i]));
    return s[ACCW-1:0];
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_acc_out", acc_out, 0);
      chk("rst_bram_en", bram_en, 0);
      chk("rst_bram_we", bram_we, 0);
      chk("rst_ld_ready", ld_ready, !start);
      m_cnt = 0;
      m_ptr = 0;
      m_acc_out = '0;
    end else begin
      m_wr    = (m_cnt == 0) && !start && ld_valid;
      m_fetch = (m_cnt >= 1) && (m_cnt <= DEPTH);
      chk("busy", busy, m_cnt != 0);
      chk("done", done, m_cnt == DEPTH + 2);
      chk("ld_ready", ld_ready, (m_cnt == 0) && !start);
      chk("bram_en", bram_en, m_wr || m_fetch);
      chk("bram_we", bram_we, m_wr);
      chk("acc_out", acc_out, m_acc_out);
      if (m_fetch) begin
        chk("fetch_addr", bram_addr, m_cnt - 1);
        chk("fetch_x_addr", x_addr, m_cnt - 1);
      end
      if (m_wr) begin
        chk("wr_addr", bram_addr, m_ptr);
        chk("wr_data", bram_di, ld_data);
        if (wr_count == 0) first_wr_addr = int'(bram_addr);
        last_wr_addr = int'(bram_addr);
        wr_count++;
        m_w[m_ptr] = ld_data;
      end
      if (m_cnt == 0) begin
        if (ld_rst) m_ptr = 0;
        else if (m_wr) m_ptr = (m_ptr + 1) % DEPTH;
        if (start) begin
          m_cnt = 1;
          m_acc_out = '0;
          m_result = dot_product();
        end
      end else if (m_cnt == DEPTH + 2) begin
        m_cnt = 0;
      end else begin
        m_cnt++;
        if (m_cnt == DEPTH + 2) m_acc_out = m_result;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: constant val, 1: value k, 2: random words with gaps and rare ld_rst
  task automatic load(input int n, input int mode, input logic [DW-1:0] val);
    int k;
    k = 0;
    while (k < n) begin
      ld_rst = 1'b0;
      if (mode == 2) begin
        ld_valid = ($urandom % 4) != 0;
        ld_data  = DW'($urandom);
        ld_rst   = ($urandom % 16) == 0;
      end else begin
        ld_valid = 1'b1;
        ld_data  = (mode == 1) ? DW'(k) : val;
      end
      if (ld_valid) k++;
      tick();
    end
    ld_valid = 1'b0;
    ld_rst   = 1'b0;
  endtask

  task automatic run_pass(input bit collide, input bit noise,
                          output int cyc, output logic [ACCW-1:0] res);
    start = 1'b1;
    if (collide) begin
      ld_valid = 1'b1;
      ld_data  = 16'hAAAA;
      #1;
      chk("collide_ld_ready", ld_ready, 0);
      chk("collide_we", bram_we, 0);
    end
    tick();
    start = 1'b0;
    ld_valid = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      if (noise && cyc < DEPTH) begin
        start    = $urandom % 2;
        ld_valid = $urandom % 2;
        ld_rst   = $urandom % 2;
        ld_data  = DW'($urandom);
      end else begin
        start = 1'b0; ld_valid = 1'b0; ld_rst = 1'b0;
      end
      tick();
      cyc++;
    end
    res = acc_out;
    tick();
  endtask

  int              cyc;
  int              wr_before;
  int              done_pulses;
  logic [ACCW-1:0] res;

  initial begin
    rst_n = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_rst = 1'b0; ld_data = '0;
    for (int i = 0; i < 32; i++) begin mem[i] = '0; xmem[i] = '0; end
    for (int i = 0; i < DEPTH; i++) m_w[i] = '0;
    repeat (3) tick();
    chk("reset_ld_ready", ld_ready, 1);
    chk("reset_bram_addr", bram_addr, 0);
    chk("reset_x_addr", x_addr, 0);
    chk("reset_bram_di", bram_di, 0);
    rst_n = 1'b1;
    tick();

    // Unit weights, X[i] = i
    for (int i = 0; i < DEPTH; i++) xmem[i] = DW'(i);
    wr_count = 0;
    load(DEPTH, 0, 16'h0001);
    chk("unit_wr_count", wr_count, 28);
    chk("unit_first_addr", first_wr_addr, 0);
    chk("unit_last_addr", last_wr_addr, 27);
    run_pass(0, 0, cyc, res);
    $display("[TB] pass unit: cycles=%0d acc=%0d", cyc, $signed(res));
    chk("unit_done_latency", cyc, 30);
    chk("unit_acc", res, 40'd378);

    // Signed: W = -1, X = 0x7FFF; pointer must have wrapped back to 0
    for (int i = 0; i < DEPTH; i++) xmem[i] = 16'h7FFF;
    wr_count = 0;
    load(DEPTH, 0, 16'hFFFF);
    chk("ptr_wrapped_to_0", first_wr_addr, 0);
    run_pass(0, 0, cyc, res);
    $display("[TB] pass signed: cycles=%0d acc=%0h", cyc, res);
    chk("signed_acc", res, 40'hFF_FFF2_001C);

    // START / LD_VALID collision
    wr_before = wr_count;
    run_pass(1, 0, cyc, res);
    $display("[TB] pass collide: cycles=%0d acc=%0h", cyc, res);
    chk("collide_no_write", wr_count, wr_before);
    chk("collide_acc", res, 40'hFF_FFF2_001C);
    chk("collide_latency", cyc, 30);

    // Ignored inputs while busy
    run_pass(0, 1, cyc, res);
    $display("[TB] pass noise: cycles=%0d acc=%0h", cyc, res);
    chk("noise_latency", cyc, 30);
    chk("noise_acc", res, 40'hFF_FFF2_001C);
    chk("noise_no_write", wr_count, wr_before);

    // Reset at FETCH index 10
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_acc_out", acc_out, 0);
    chk("abort_bram_en", bram_en, 0);
    tick();
    rst_n = 1'b1;
    done_pulses = 0;
    repeat (40) begin
      tick();
      if (done) done_pulses++;
    end
    $display("[TB] abort: done pulses after reset=%0d", done_pulses);
    chk("abort_no_done", done_pulses, 0);
    run_pass(0, 0, cyc, res);
    $display("[TB] pass after abort: cycles=%0d acc=%0h", cyc, res);
    chk("after_abort_acc", res, 40'hFF_FFF2_001C);

    // Pointer wrap: 30 words of value k; X selects addresses 0 and 1
    for (int i = 0; i < DEPTH; i++) xmem[i] = (i < 2) ? 16'd1 : 16'd0;
    load(30, 1, '0);
    run_pass(0, 0, cyc, res);
    $display("[TB] pass wrap: cycles=%0d acc=%0d", cyc, $signed(res));
    chk("wrap_acc", res, 40'd57);

    // LD_RST together with LD_VALID: write lands at ptr 2, then ptr is 0
    ld_valid = 1'b1; ld_rst = 1'b1; ld_data = 16'h1234;
    tick();
    ld_rst = 1'b0; ld_data = 16'h0055;
    tick();
    ld_valid = 1'b0;
    chk("ldrst_next_addr", last_wr_addr, 0);
    for (int i = 0; i < DEPTH; i++) xmem[i] = (i == 2) ? 16'd1 : 16'd0;
    run_pass(0, 0, cyc, res);
    $display("[TB] pass ldrst: cycles=%0d acc=%0h", cyc, res);
    chk("ldrst_acc", res, 40'h1234);

    // Randomized loads and passes, checked cycle-by-cycle by the model
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < DEPTH; i++) xmem[i] = DW'($urandom);
      load(DEPTH, 2, '0);
      run_pass(r[0], 1, cyc, res);
      $display("[TB] pass random %0d: cycles=%0d acc=%0h", r, cyc, res);
      chk("random_latency", cyc, 30);
    end

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #300000;
    fail_cnt++;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $fatal(1);
  end

endmodule
